// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } fq_entry_t;

endpackage

// File: rtl/fq_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
module fq_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  // NOTE: storage is deliberately left unreset; the pointers and count alone decide
  // which entries are meaningful, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer with valid/ready on both sides
// and a single-cycle flush for branch/jump redirects.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [WIDTH-1:0]         f_instr,
  input  logic [WIDTH-1:0]         f_pc,
  input  logic [WIDTH-1:0]         f_pcplus4,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [WIDTH-1:0]         d_instr,
  output logic [WIDTH-1:0]         d_pc,
  output logic [WIDTH-1:0]         d_pcplus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     rd_entry;

  assign f_ready = (count != CW'(DEPTH));
  assign d_valid = (count != '0);

  // Reset is folded in so a fetch arriving during reset never touches storage.
  assign push = f_valid & f_ready & ~flush & rst;
  assign pop  = d_valid & d_ready & ~flush & rst;

  assign wr_entry = '{instr: f_instr, pc: f_pc, pcplus4: f_pcplus4};

  fq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every output gets its empty-queue value first so no path leaves it unassigned.
  always_comb begin
    d_instr   = NOP_INSTR;
    d_pc      = '0;
    d_pcplus4 = '0;
    if (d_valid) begin
      d_instr   = rd_entry.instr;
      d_pc      = rd_entry.pc;
      d_pcplus4 = rd_entry.pcplus4;
    end
  end

endmodule
